operand_skewer: RTL and testbench
=================================

// Module: operand_skewer
// PURPOSE
// - Upstream feeder for the N x N systolic PE array.
// - Accepts K row-vectors of N operands through a valid/ready handshake.
// - Drives them onto the array's west edge with diagonal skew: lane i is delayed by i extra cycles.
// - Generates acc_en for the PEs, flushes the wavefront through the array, and pulses done when
//   the accumulators hold final results.
// PARAMETERS
// - DATA_WIDTH  16  operand width; matches the PE data width.
// - N           4   lanes, equal to the array dimension; legal range N >= 2.
// - K_W         8   width of k_len; K ranges 1 .. 2^K_W-1.
// PORTS
// - clk       in   1             clock; all logic on the rising edge.
// - rst       in   1             reset; synchronous, active-high.
// - start     in   1             begin a job; sampled only in IDLE.
// - k_len     in   K_W           number of vectors in the job; sampled with start.
// - in_valid  in   1             in_data holds a vector.
// - in_ready  out  1             skewer accepts a vector this cycle.
// - in_data   in   N*DATA_WIDTH  lane i = in_data[i*DATA_WIDTH +: DATA_WIDTH], signed.
// - out_data  out  N*DATA_WIDTH  skewed lanes to the array edge data_a_i inputs.
// - acc_en    out  1             accumulator enable broadcast to all PEs.
// - busy      out  1             high in LOAD or FLUSH.
// - done      out  1             one-cycle pulse at job completion.
// BEHAVIOUR
// - Reset: state IDLE; all delay registers = 0.
//   Outputs after reset: out_data=0, in_ready=0, acc_en=0, busy=0, done=0.
// - FSM states: IDLE -> LOAD -> FLUSH -> DONE -> IDLE.
// - IDLE:
//   - start=1 with k_len!=0: latch k_len, clear counters, go to LOAD.
//   - start=1 with k_len==0: ignored; stay IDLE, no done pulse.
// - LOAD:
//   - in_ready=1.
//   - Accept = in_valid && in_ready; each accept increments vec_cnt.
//   - The accept of vector k_len-1 (0-based) moves the FSM to FLUSH next cycle.
// - Bubbles in LOAD: a cycle with in_valid=0 injects an all-zero vector and acc_en stays 1.
//   Zeros add nothing to the accumulators, so the result is unaffected.
// - FLUSH:
//   - in_ready=0.
//   - Zeros are injected for exactly 2N-2 cycles: N-1 to drain the skew, N-1 to cross the array.
//   - Then go to DONE.
// - DONE: done=1 for one cycle, acc_en=0, then IDLE.
// - acc_en = 1 in LOAD and FLUSH, 0 otherwise. busy = (state==LOAD || state==FLUSH).
// - Skew: the operand injected at cycle t on lane i appears on out_data lane i at t+1+i.
//   Lane 0 has one register stage; lane i has i+1 stages.
// - Injected vector = accepted in_data on accept, else all zeros. No arithmetic, values pass
//   unmodified.
// - start asserted while busy or in DONE is ignored; k_len changes mid-job are ignored.
// - in_valid in IDLE, FLUSH or DONE: no accept, no state change, in_data ignored.
// - rst mid-job: next cycle is IDLE with all delay registers zeroed. No done pulse. Partial data
//   is discarded.
// - Counters: vec_cnt is K_W bits; flush_cnt is $clog2(2N-1) bits. Neither wraps, because the
//   exit conditions are exact compares.
// STRUCTURE
// - Shared package systolic_pkg:
//   - typedef skew_state_e {IDLE, LOAD, FLUSH, DONE}.
//   - localparam function flush_len(N) = 2*N-2.
//   - operand typedef logic signed [DATA_WIDTH-1:0].
// - Sub-module skew_delay_line #(DATA_WIDTH, DEPTH): shift register with synchronous zero on rst.
//   - Instantiated N times via generate, with DEPTH = i+1.
// - The FSM and counters live in operand_skewer itself.
// TESTING
// - T1 reset: hold rst 2 cycles with in_valid=1 and start=1.
//   -> All outputs 0; out_data 0 for 5 cycles after release.
// - T2 skew timing (N=4): start with k_len=1, vector {4,3,2,1} accepted at cycle c.
//   -> lane0=1 at c+1, lane1=2 at c+2, lane2=3 at c+3, lane3=4 at c+4.
//   -> acc_en high c..c+6; done at c+7.
// - T3 bubbles: k_len=3 with in_valid pattern 1,0,1,0,1.
//   -> Exactly 3 accepts; zero vectors on bubble cycles; FLUSH starts after the 3rd accept.
//   -> done once.
// - T4 end-to-end with a 4x4 PE array: A=[[1,2,..]] rows and identity weights, K=4.
//   -> PE acc_o equals the reference matmul at done.
// - T5 abort: rst asserted mid-LOAD after 2 of 4 vectors.
//   -> IDLE next cycle, no done, delay lines zero.
//   -> A fresh job then produces correct results.
// - T6 illegal: start with k_len=0, and start while busy.
//   -> No state change; in_ready unaffected; no extra done.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the systolic array front end
package systolic_pkg;
  localparam int OPERAND_W = 16;
  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} skew_state_e;
  function automatic int flush_len(input int n);
    return 2 * n - 2;
  endfunction
endpackage

// File: rtl/operand_skewer_if.sv
// operand_skewer_if: job control, input stream and skewed array-edge bundle
interface operand_skewer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int K_W        = 8
);
  logic                    start;
  logic [K_W-1:0]          k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_data;
  logic [N*DATA_WIDTH-1:0] out_data;
  logic                    acc_en;
  logic                    busy;
  logic                    done;
  modport master (
    output start, k_len, in_valid, in_data,
    input  in_ready, out_data, acc_en, busy, done
  );
  modport slave (
    input  start, k_len, in_valid, in_data,
    output in_ready, out_data, acc_en, busy, done
  );
endinterface

// File: rtl/operand_skewer_delay_line.sv
// skew_delay_line: DEPTH-stage shift register cleared synchronously on rst
module skew_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] sr_q [DEPTH];
  // shift one stage per cycle, stage 0 takes the new operand
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) sr_q[j] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int j = 1; j < DEPTH; j++) sr_q[j] <= sr_q[j-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/operand_skewer.sv
// operand_skewer: accepts K vectors and feeds them diagonally skewed into the PE array
module operand_skewer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int K_W        = 8
) (
  input logic             clk,
  input logic             rst,
  operand_skewer_if.slave bus
);
  localparam int FLUSH_LEN = flush_len(N);
  localparam int FC_W      = $clog2(2 * N - 1);
  skew_state_e             state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [K_W-1:0]          vec_cnt_q, vec_cnt_d;
  logic [FC_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic                    accept;
  logic [N*DATA_WIDTH-1:0] inj;
  logic [DATA_WIDTH-1:0]   lane [N];
  assign accept       = bus.in_valid && bus.in_ready;
  assign inj          = accept ? bus.in_data : '0;
  assign bus.in_ready = state_q == LOAD;
  assign bus.busy     = state_q == LOAD || state_q == FLUSH;
  assign bus.acc_en   = bus.busy;
  assign bus.done     = state_q == DONE;
  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      vec_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      vec_cnt_q   <= vec_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  // job sequencing: exact compares on the counters end LOAD and FLUSH
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    vec_cnt_d   = vec_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: if (bus.start && bus.k_len != '0) begin
        state_d     = LOAD;
        k_d         = bus.k_len;
        vec_cnt_d   = '0;
        flush_cnt_d = '0;
      end
      LOAD: if (accept) begin
        vec_cnt_d = vec_cnt_q + K_W'(1);
        state_d   = vec_cnt_q == k_q - K_W'(1) ? FLUSH : LOAD;
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FC_W'(1);
        state_d     = flush_cnt_q == FC_W'(FLUSH_LEN - 1) ? DONE : FLUSH;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_dl (
      .clk (clk),
      .rst (rst),
      .d_i (inj[i*DATA_WIDTH +: DATA_WIDTH]),
      .q_o (lane[i])
    );
  end
  // pack the delayed lanes onto the array edge
  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < N; j++) bus.out_data[j*DATA_WIDTH +: DATA_WIDTH] = lane[j];
  end
endmodule

// File: tb/tb_operand_skewer.sv
// tb_operand_skewer: directed checks of skew timing, bubbles, abort and illegal starts
module tb_operand_skewer;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  operand_skewer_if #(.DATA_WIDTH(16), .N(4), .K_W(8)) bus ();
  operand_skewer #(.DATA_WIDTH(16), .N(4), .K_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic single_job(input string tag, input logic [63:0] v);
    logic [63:0] e;
    bus.start = 1'b1;
    bus.k_len = 8'd1;
    tick;
    bus.start    = 1'b0;
    chk({tag, " ready_c"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " acc_en_c"}, 64'(bus.acc_en), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int t = 1; t <= 8; t++) begin
      tick;
      bus.in_valid = 1'b0;
      e = '0;
      if (t <= 4) e[16*(t-1) +: 16] = v[16*(t-1) +: 16];
      chk($sformatf("%s out c+%0d", tag, t), bus.out_data, e);
      chk($sformatf("%s acc_en c+%0d", tag, t), 64'(bus.acc_en), 64'(t <= 6));
      chk($sformatf("%s done c+%0d", tag, t), 64'(bus.done), 64'(t == 7));
      if (t == 1) chk({tag, " ready_c+1"}, 64'(bus.in_ready), 64'd0);
    end
    chk({tag, " idle"}, 64'(bus.busy), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int          res [4][4];
    int          s;
    int          done_cnt;
    logic [4:0]  pat;
    logic [63:0] v;
    // T1 reset with start and in_valid asserted
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.k_len    = 8'd3;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0004_0003_0002_0001;
    tick;
    tick;
    chk("rst out_data", bus.out_data, 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst acc_en", 64'(bus.acc_en), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick;
      chk($sformatf("post-rst out %0d", t), bus.out_data, 64'd0);
      chk($sformatf("post-rst busy %0d", t), 64'(bus.busy), 64'd0);
    end
    // T2 skew timing, k_len=1
    single_job("T2", 64'h0004_0003_0002_0001);
    // T3 bubbles: valid pattern 1,0,1,0,1 with junk data on bubbles
    pat       = 5'b10101;
    bus.start = 1'b1;
    bus.k_len = 8'd3;
    tick;
    bus.start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = pat[j];
      bus.in_data  = pat[j] ? {16'(16'h40 + j), 16'(16'h30 + j), 16'(16'h20 + j), 16'(16'h10 + j)}
                            : 64'hDEAD_BEEF_CAFE_F00D;
      chk($sformatf("T3 ready %0d", j), 64'(bus.in_ready), 64'd1);
      tick;
      chk($sformatf("T3 lane0 %0d", j), 64'(bus.out_data[15:0]), pat[j] ? 64'(16'h10 + j) : 64'd0);
    end
    bus.in_valid = 1'b1;
    chk("T3 flush ready", 64'(bus.in_ready), 64'd0);
    chk("T3 flush busy", 64'(bus.busy), 64'd1);
    done_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      tick;
      if (bus.done) done_cnt++;
    end
    bus.in_valid = 1'b0;
    chk("T3 done count", 64'(done_cnt), 64'd1);
    // T4 end-to-end with identity weights: per-lane accumulation must reproduce A
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) res[i][k] = 0;
    bus.start = 1'b1;
    bus.k_len = 8'd4;
    tick;
    bus.start = 1'b0;
    s = 0;
    while (s < 20 && !bus.done) begin
      bus.in_valid = s < 4;
      for (int i = 0; i < 4; i++) bus.in_data[16*i +: 16] = 16'(i * 4 + s + 1);
      tick;
      s++;
      for (int i = 0; i < 4; i++)
        if (bus.acc_en && s - 1 - i >= 0 && s - 1 - i < 4)
          res[i][s-1-i] += int'(bus.out_data[16*i +: 16]);
    end
    bus.in_valid = 1'b0;
    chk("T4 done cycle", 64'(s), 64'd10);
    for (int i = 0; i < 4; i++)
      chk($sformatf("T4 row %0d", i),
          {16'(res[i][3]), 16'(res[i][2]), 16'(res[i][1]), 16'(res[i][0])},
          {16'(i*4+4), 16'(i*4+3), 16'(i*4+2), 16'(i*4+1)});
    // T5 abort mid-LOAD after 2 of 4 vectors
    tick;
    bus.start = 1'b1;
    bus.k_len = 8'd4;
    tick;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0011_0022_0033_0044;
    tick;
    tick;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick;
    rst = 1'b0;
    chk("T5 busy", 64'(bus.busy), 64'd0);
    chk("T5 ready", 64'(bus.in_ready), 64'd0);
    chk("T5 out", bus.out_data, 64'd0);
    chk("T5 done", 64'(bus.done), 64'd0);
    done_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick;
      if (bus.done || bus.out_data != '0) done_cnt++;
    end
    chk("T5 quiet", 64'(done_cnt), 64'd0);
    single_job("T5 fresh", 64'h0008_0007_0006_0005);
    // T6 k_len=0 ignored; start and k_len changes while busy ignored
    bus.start = 1'b1;
    bus.k_len = 8'd0;
    tick;
    chk("T6 k0 busy", 64'(bus.busy), 64'd0);
    chk("T6 k0 ready", 64'(bus.in_ready), 64'd0);
    bus.k_len = 8'd2;
    tick;
    chk("T6 load ready", 64'(bus.in_ready), 64'd1);
    bus.k_len    = 8'd5;
    bus.in_valid = 1'b1;
    v            = 64'h0001_0001_0001_0001;
    bus.in_data  = v;
    tick;
    tick;
    bus.in_valid = 1'b0;
    chk("T6 flush after 2", 64'(bus.in_ready), 64'd0);
    chk("T6 busy", 64'(bus.busy), 64'd1);
    tick;
    bus.start = 1'b0;
    done_cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick;
      if (bus.done) done_cnt++;
    end
    chk("T6 done count", 64'(done_cnt), 64'd1);
    chk("T6 final idle", 64'(bus.busy), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
